// File: rtl/life_manager_pkg.sv
// rtl/life_manager_pkg.sv - shared game types and constants for life handling and the life-bar renderer
package life_manager_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Also the renderer's bar length in pixels.
    localparam int MAX_LIFE       = 100;
    localparam int LIFE_GREEN_MIN = 50;

    // The survivor wins; both dead in the same cycle is a draw.
    function automatic winner_t decide_winner(input logic dead1, input logic dead2);
        return winner_t'({dead1, dead2});
    endfunction

endpackage

// File: rtl/life_manager_player_life.sv
// rtl/life_manager_player_life.sv - one player's life register, invulnerability window and hit/heal saturation
module player_life #(
    parameter int MAX_LIFE     = life_manager_pkg::MAX_LIFE,
    parameter int HIT_DAMAGE   = 25,
    parameter int HEAL_AMOUNT  = 10,
    parameter int INVUL_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       heal,
    input  logic       freeze,
    input  logic       reload,
    output logic [6:0] life,
    output logic       invul
);

    localparam int CW = $clog2(INVUL_FRAMES + 1);

    logic [CW-1:0] cnt_q;
    logic          hit_ok;
    logic          heal_ok;
    logic [7:0]    heal_sum;
    logic [6:0]    heal_life;
    logic [6:0]    hit_life;

    always_comb begin
        hit_ok    = hit && (cnt_q == '0) && !freeze;
        heal_ok   = heal && !hit_ok && (life != '0) && !freeze;
        // 8-bit sum so a heal near the ceiling cannot wrap before clamping.
        heal_sum  = {1'b0, life} + 8'(HEAL_AMOUNT);
        heal_life = (heal_sum > 8'(MAX_LIFE)) ? 7'(MAX_LIFE) : heal_sum[6:0];
        hit_life  = (life > 7'(HIT_DAMAGE)) ? life - 7'(HIT_DAMAGE) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            life  <= 7'(MAX_LIFE);
            cnt_q <= '0;
        end else if (freeze) begin
            cnt_q <= '0;
        end else if (hit_ok) begin
            life  <= hit_life;
            cnt_q <= CW'(INVUL_FRAMES);
        end else begin
            if (heal_ok) begin
                life <= heal_life;
            end
            if (frame_tick && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign invul = (cnt_q != '0);

endmodule

// File: rtl/life_manager.sv
// rtl/life_manager.sv - both players' lives plus the PLAY/OVER round state machine and winner
module life_manager #(
    parameter int MAX_LIFE     = life_manager_pkg::MAX_LIFE,
    parameter int HIT_DAMAGE   = 25,
    parameter int HEAL_AMOUNT  = 10,
    parameter int INVUL_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       heal1,
    input  logic       heal2,
    input  logic       restart,
    output logic [6:0] life1,
    output logic [6:0] life2,
    output logic       invul1,
    output logic       invul2,
    output logic       game_over,
    output logic [1:0] winner
);

    import life_manager_pkg::*;

    localparam int OW = $clog2(OVER_FRAMES + 1);

    state_t        state_q, state_d;
    winner_t       win_q, win_d;
    logic [OW-1:0] ocnt_q, ocnt_d;
    logic          reload;
    logic          freeze;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ocnt_d  = ocnt_q;
        reload  = 1'b0;
        case (state_q)
            PLAY: begin
                if ((life1 == '0) || (life2 == '0)) begin
                    state_d = OVER;
                    ocnt_d  = OW'(OVER_FRAMES);
                    win_d   = decide_winner(life1 == '0, life2 == '0);
                end
            end
            OVER: begin
                if (restart && (ocnt_q == '0)) begin
                    state_d = PLAY;
                    win_d   = WIN_NONE;
                    reload  = 1'b1;
                end else if (frame_tick && (ocnt_q != '0)) begin
                    ocnt_d = ocnt_q - 1'b1;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLAY;
            win_q   <= WIN_NONE;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Reload has priority inside player_life, so the restart cycle re-arms despite freeze.
    assign freeze = (state_q == OVER);

    player_life #(
        .MAX_LIFE    (MAX_LIFE),
        .HIT_DAMAGE  (HIT_DAMAGE),
        .HEAL_AMOUNT (HEAL_AMOUNT),
        .INVUL_FRAMES(INVUL_FRAMES)
    ) u_p1 (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .hit       (hit1),
        .heal      (heal1),
        .freeze    (freeze),
        .reload    (reload),
        .life      (life1),
        .invul     (invul1)
    );

    player_life #(
        .MAX_LIFE    (MAX_LIFE),
        .HIT_DAMAGE  (HIT_DAMAGE),
        .HEAL_AMOUNT (HEAL_AMOUNT),
        .INVUL_FRAMES(INVUL_FRAMES)
    ) u_p2 (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .hit       (hit2),
        .heal      (heal2),
        .freeze    (freeze),
        .reload    (reload),
        .life      (life2),
        .invul     (invul2)
    );

    assign game_over = (state_q == OVER);
    assign winner    = win_q;

endmodule

// File: tb/tb_life_manager.sv
// tb/tb_life_manager.sv - self-checking bench for life_manager against a behavioural round model
module tb_life_manager;

    localparam int MAXL  = 100;
    localparam int DMG   = 25;
    localparam int HEAL  = 10;
    localparam int INVF  = 60;
    localparam int OVERF = 180;

    logic       clk = 1'b0;
    logic       reset = 1'b0, frame_tick = 1'b0, restart = 1'b0;
    logic       hit1 = 1'b0, hit2 = 1'b0, heal1 = 1'b0, heal2 = 1'b0;
    logic [6:0] life1, life2;
    logic       invul1, invul2, game_over;
    logic [1:0] winner;

    int n_tests = 0;
    int n_fail  = 0;

    life_manager dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .hit1      (hit1),
        .hit2      (hit2),
        .heal1     (heal1),
        .heal2     (heal2),
        .restart   (restart),
        .life1     (life1),
        .life2     (life2),
        .invul1    (invul1),
        .invul2    (invul2),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    // Round model: lives, remaining invulnerable frames, round over flag, frames left before restart.
    int m_life[2];
    int m_inv[2];
    int m_left;
    int m_win;
    bit m_over;
    bit m_valid = 1'b0;
    bit mh[2];
    bit me[2];

    always @(posedge clk) begin
        mh[0] = hit1;  mh[1] = hit2;
        me[0] = heal1; me[1] = heal2;
        if (reset) begin
            m_life[0] = MAXL; m_life[1] = MAXL;
            m_inv[0] = 0; m_inv[1] = 0;
            m_over = 0; m_left = 0; m_win = 0;
            m_valid = 1'b1;
        end else if (!m_over) begin
            if (m_life[0] == 0 || m_life[1] == 0) begin
                m_over = 1;
                m_left = OVERF;
                if (m_life[0] == 0 && m_life[1] == 0) m_win = 3;
                else if (m_life[1] == 0)              m_win = 1;
                else                                  m_win = 2;
            end
            for (int p = 0; p < 2; p++) begin
                if (mh[p] && m_inv[p] == 0) begin
                    m_life[p] = (m_life[p] > DMG) ? m_life[p] - DMG : 0;
                    m_inv[p]  = INVF;
                end else begin
                    if (frame_tick && m_inv[p] > 0) m_inv[p] = m_inv[p] - 1;
                    if (me[p] && m_life[p] > 0)
                        m_life[p] = (m_life[p] + HEAL > MAXL) ? MAXL : m_life[p] + HEAL;
                end
            end
        end else begin
            m_inv[0] = 0; m_inv[1] = 0;
            if (restart && m_left == 0) begin
                m_over = 0; m_win = 0;
                m_life[0] = MAXL; m_life[1] = MAXL;
            end else if (frame_tick && m_left > 0) begin
                m_left = m_left - 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model life1", 32'(life1), 32'(m_life[0]));
            check("model life2", 32'(life2), 32'(m_life[1]));
            check("model invul1", 32'(invul1), 32'(m_inv[0] != 0));
            check("model invul2", 32'(invul2), 32'(m_inv[1] != 0));
            check("model game_over", 32'(game_over), 32'(m_over));
            check("model winner", 32'(winner), 32'(m_over ? m_win : 0));
        end
    end

    task automatic cyc(input bit h1, input bit h2, input bit e1, input bit e2,
                       input bit t, input bit r, input bit rs);
        hit1 = h1; hit2 = h2; heal1 = e1; heal2 = e2;
        frame_tick = t; restart = r; reset = rs;
        @(negedge clk);
        hit1 = 0; hit2 = 0; heal1 = 0; heal2 = 0;
        frame_tick = 0; restart = 0; reset = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("reset life1", 32'(life1), 100);
        check("reset life2", 32'(life2), 100);
        check("reset invul1", 32'(invul1), 0);
        check("reset game_over", 32'(game_over), 0);
        check("reset winner", 32'(winner), 0);

        cyc(1, 0, 0, 0, 0, 0, 0);
        check("first hit life1", 32'(life1), 75);
        check("first hit invul1", 32'(invul1), 1);
        check("first hit life2", 32'(life2), 100);
        ticks(10);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("invul hit ignored", 32'(life1), 75);
        ticks(49);
        check("invul at 59 frames", 32'(invul1), 1);
        ticks(1);
        check("invul expired", 32'(invul1), 0);

        cyc(1, 0, 0, 0, 0, 0, 0);
        check("hit to 50", 32'(life1), 50);
        ticks(60);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("hit to 25", 32'(life1), 25);
        ticks(60);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("hit to 0", 32'(life1), 0);
        check("not over yet", 32'(game_over), 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("dead takes no heal", 32'(life1), 0);
        check("p2 wins over", 32'(game_over), 1);
        check("p2 wins winner", 32'(winner), 2);

        cyc(0, 0, 0, 0, 0, 1, 0);
        check("early restart ignored", 32'(game_over), 1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("over hit1 ignored", 32'(life1), 0);
        check("over hit2 ignored", 32'(life2), 100);
        ticks(179);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("restart at 179 ignored", 32'(game_over), 1);
        ticks(1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("restart game_over", 32'(game_over), 0);
        check("restart life1", 32'(life1), 100);
        check("restart life2", 32'(life2), 100);
        check("restart winner", 32'(winner), 0);

        cyc(0, 1, 0, 0, 0, 0, 0);
        check("p2 hit", 32'(life2), 75);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("heal while invul", 32'(life2), 85);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("heal to 95", 32'(life2), 95);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("heal clamped", 32'(life2), 100);
        ticks(60);
        cyc(0, 1, 0, 0, 0, 0, 0);
        ticks(60);
        cyc(0, 1, 0, 1, 0, 0, 0);
        check("hit beats heal", 32'(life2), 50);
        ticks(60);

        cyc(1, 1, 0, 0, 0, 0, 0);
        check("draw prep life2", 32'(life2), 25);
        ticks(60);
        cyc(1, 0, 0, 0, 0, 0, 0);
        ticks(60);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("draw prep life1", 32'(life1), 25);
        ticks(60);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("draw life1", 32'(life1), 0);
        check("draw life2", 32'(life2), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("draw over", 32'(game_over), 1);
        check("draw winner", 32'(winner), 3);

        cyc(0, 0, 0, 0, 0, 0, 1);
        check("mid-over reset life1", 32'(life1), 100);
        check("mid-over reset game_over", 32'(game_over), 0);
        check("mid-over reset winner", 32'(winner), 0);

        for (int i = 0; i < 15000; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1999) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
